// File: rtl/sr_pulse_arbiter.sv
// sr_pulse_arbiter: arbitrates set/clear requests from two requesters onto the S/R inputs of
// an external SR latch. Each grant produces a PULSE_CYCLES-wide pulse on S or R, followed by a
// GAP_CYCLES recovery window with S=R=0. The latch Q is read back through a 2-flop synchronizer
// in the last gap cycle, and any mismatch raises a sticky err flag.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   set_req  - requester A: set the latch (held until set_ack)
//   clr_req  - requester B: clear the latch (held until clr_ack)
//   q_in     - latch Q readback, asynchronous to clk
//   S, R     - registered latch drive, never both high
//   set_ack  - one-cycle pulse in the first gap cycle after a set pulse
//   clr_ack  - one-cycle pulse in the first gap cycle after a clear pulse
//   busy     - high whenever the FSM is not in IDLE
//   err      - sticky readback mismatch flag, cleared only by rst
module sr_pulse_arbiter #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_in,
  output logic S,
  output logic R,
  output logic set_ack,
  output logic clr_ack,
  output logic busy,
  output logic err
);

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;

  localparam logic [3:0] PulseLoad = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GapLoad   = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;  // 1: most recent grant was SET, 0: CLR
  logic       q_meta;
  logic       q_sync;
  logic       grant_set;

  // With both requests pending, alternate away from the previous grant.
  assign grant_set = set_req && (!clr_req || !last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b0;
      q_meta     <= 1'b0;
      q_sync     <= 1'b0;
      S          <= 1'b0;
      R          <= 1'b0;
      set_ack    <= 1'b0;
      clr_ack    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      q_meta  <= q_in;
      q_sync  <= q_meta;
      set_ack <= 1'b0;
      clr_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (set_req || clr_req) begin
            cnt        <= PulseLoad;
            busy       <= 1'b1;
            last_grant <= grant_set;
            if (grant_set) begin
              state <= SET_P;
              S     <= 1'b1;
            end else begin
              state <= CLR_P;
              R     <= 1'b1;
            end
          end
        end
        SET_P, CLR_P: begin
          // Requests are not looked at here, so a dropped request still gets a full pulse.
          if (cnt == 4'd0) begin
            state   <= GAP;
            cnt     <= GapLoad;
            S       <= 1'b0;
            R       <= 1'b0;
            set_ack <= (state == SET_P);
            clr_ack <= (state == CLR_P);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        GAP: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            // Q must have settled to the value implied by the operation just performed.
            if (q_sync != last_grant) begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          S     <= 1'b0;
          R     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pulse_arbiter.sv
// Testbench for sr_pulse_arbiter with an SR latch model in the loop. A schedule-based reference
// model turns each grant decision into expected S/R/busy windows, an ack queue and an err onset;
// a separate monitor compares the DUT against those expectations every cycle.
module tb_sr_pulse_arbiter;

  localparam int P    = 4;
  localparam int G    = 3;
  localparam int MAXC = 12000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic q_latch = 1'b0;
  logic stuck = 1'b0;
  logic S, R, set_ack, clr_ack, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sr_pulse_arbiter #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .set_req(set_req),
    .clr_req(clr_req),
    .q_in   (q_latch),
    .S      (S),
    .R      (R),
    .set_ack(set_ack),
    .clr_ack(clr_ack),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  // SR latch; stuck forces Q low to emulate a broken latch.
  always @(S or R or stuck) begin
    if (stuck) q_latch = 1'b0;
    else if (S) q_latch = 1'b1;
    else if (R) q_latch = 1'b0;
  end

  // Reference model state
  typedef struct {
    int cyc;
    bit is_set;
  } ack_t;

  bit   exp_s[MAXC];
  bit   exp_r[MAXC];
  bit   exp_busy[MAXC];
  ack_t ackq[$];
  int   free_at = 0;
  bit   m_last_set = 1'b0;
  int   err_at = -1;

  task automatic model_reset();
    for (int c = cyc; c < MAXC; c++) begin
      exp_s[c]    = 1'b0;
      exp_r[c]    = 1'b0;
      exp_busy[c] = 1'b0;
    end
    ackq.delete();
    free_at    = 0;
    m_last_set = 1'b0;
    err_at     = -1;
  endtask

  // Decide the grant taken at the edge that ends cycle cyc, from the requests seen in that cycle.
  task automatic model_step();
    int g;
    bit op_set;
    if (!rst && cyc >= free_at && (set_req || clr_req)) begin
      g          = cyc + 1;
      op_set     = (set_req && clr_req) ? !m_last_set : set_req;
      m_last_set = op_set;
      for (int k = 0; k < P + G; k++) begin
        if (g + k < MAXC) begin
          exp_busy[g + k] = 1'b1;
          if (k < P) begin
            if (op_set) exp_s[g + k] = 1'b1;
            else exp_r[g + k] = 1'b1;
          end
        end
      end
      ackq.push_back('{cyc: g + P, is_set: op_set});
      free_at = g + P + G;
      if (op_set && stuck && err_at < 0) err_at = g + P + G;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    cyc <= cyc + 1;
  end

  task automatic fail_line(input string name, input int act, input int exp);
    errors++;
    $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) fail_line(name, int'(act), int'(exp));
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ack_t e;
    check("s_and_r_exclusive", S && R, 1'b0);
    if (cyc < MAXC) begin
      check("S", S, exp_s[cyc]);
      check("R", R, exp_r[cyc]);
      check("busy", busy, exp_busy[cyc]);
      check("err", err, (err_at >= 0) && (cyc >= err_at));
    end
    if (set_ack || clr_ack) begin
      checks++;
      if (set_ack && clr_ack) begin
        fail_line("double_ack", 1, 0);
      end else if (ackq.size() == 0) begin
        fail_line("spurious_ack", int'(set_ack), 0);
      end else begin
        e = ackq.pop_front();
        if (e.cyc != cyc) fail_line("ack_cycle", cyc, e.cyc);
        else if (e.is_set != set_ack) fail_line("ack_kind_set", int'(set_ack), int'(e.is_set));
      end
    end else if (ackq.size() > 0 && ackq[0].cyc <= cyc) begin
      checks++;
      e = ackq.pop_front();
      fail_line("missed_ack", 0, e.cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, dropping each request once its ack appears.
  task automatic run_drop(input int n);
    repeat (n) begin
      step();
      if (set_ack) set_req = 1'b0;
      if (clr_ack) clr_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    rst = 1'b0;

    // Both requests held: alternating SET, CLR, SET, CLR grants.
    set_req = 1'b1;
    clr_req = 1'b1;
    repeat (33) step();
    set_req = 1'b0;
    clr_req = 1'b0;
    run_drop(12);

    // Set alone.
    set_req = 1'b1;
    run_drop(14);

    // Clear request lasting a single cycle still gets a full pulse and ack.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    run_drop(12);

    // Reset in pulse cycle 2 truncates the pulse; a later request is served normally.
    set_req = 1'b1;
    step();
    step();
    set_req = 1'b0;
    do_reset();
    clr_req = 1'b1;
    run_drop(14);

    // Latch stuck at 0 during a set: err rises and stays through a later clear.
    stuck = 1'b1;
    set_req = 1'b1;
    run_drop(12);
    clr_req = 1'b1;
    run_drop(14);
    do_reset();
    stuck = 1'b0;
    run_drop(4);

    // Random request stream, including early drops while waiting or mid-pulse.
    repeat (10000) begin
      step();
      if (set_req && set_ack) set_req = 1'b0;
      else if (!set_req && $urandom_range(3) == 0) set_req = 1'b1;
      else if (set_req && $urandom_range(31) == 0) set_req = 1'b0;
      if (clr_req && clr_ack) clr_req = 1'b0;
      else if (!clr_req && $urandom_range(3) == 0) clr_req = 1'b1;
      else if (clr_req && $urandom_range(31) == 0) clr_req = 1'b0;
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    run_drop(20);

    checks++;
    if (ackq.size() != 0) fail_line("acks_outstanding", ackq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
